// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, canonical NOP and the fetch-queue entry.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Clears the byte-offset bits of an address.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries. Flush dominates push/pop;
// push and pop may coincide at any occupancy, including full.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    fetch_entry_t    mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic            do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && !empty;
        // When full, the slot being written is the one being popped this cycle.
        do_push  = push && (!full || do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Entry storage; contents are don't-care while not counted as occupied.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited reads on the
// shared memory port, queues returned words and presents one instruction per cycle.
// ALU-stage redirects flush the queue and drop any returning response.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus_4
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [31:0]     fpc_q, fpc_d;
    logic            inflight_q, inflight_d;
    logic [31:0]     inflight_pc_q, inflight_pc_d;

    logic            grant;
    logic            q_push, q_pop, q_full, q_empty;
    logic [PW:0]     q_count;
    logic [PW+1:0]   credit_used;
    fetch_entry_t    q_head, push_entry;

    // A pop this cycle frees its slot for credit only from the next cycle, since
    // credit is computed from registered occupancy.
    assign credit_used = {1'b0, q_count} + (PW+2)'(inflight_q);
    assign imem_req    = !reset && !redirect && !q_full && (credit_used < (PW+2)'(DEPTH));
    assign imem_addr   = word_align(fpc_q);
    assign grant       = imem_req && imem_gnt;

    // A response is only accepted against a recorded grant and never in a redirect cycle.
    assign q_push           = imem_rvalid && inflight_q && !redirect && !reset;
    assign push_entry.pc    = inflight_pc_q;
    assign push_entry.instr = imem_rdata;
    assign q_pop            = instr_valid && !stall;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (q_push),
        .push_entry (push_entry),
        .pop        (q_pop),
        .flush      (redirect),
        .full       (q_full),
        .empty      (q_empty),
        .count      (q_count),
        .head       (q_head)
    );

    assign instr_valid = !q_empty;
    assign instr       = q_empty ? NOP_INSTR : q_head.instr;
    assign pc          = q_empty ? '0 : q_head.pc;
    assign pc_plus_4   = q_empty ? '0 : q_head.pc + 32'd4;

    // Fetch PC advance, redirect retarget and in-flight tracking.
    always_comb begin
        fpc_d         = fpc_q;
        inflight_d    = grant;
        inflight_pc_d = inflight_pc_q;
        if (redirect) begin
            fpc_d      = word_align(redirect_pc);
            inflight_d = 1'b0;
        end else if (grant) begin
            fpc_d         = fpc_q + 32'd4;
            inflight_pc_d = fpc_q;
        end
    end

    // Fetch-side state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q         <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fpc_q         <= fpc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

endmodule
